// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: merges ALU results and load responses,
// tracks one outstanding load, aligns and extends its data, and stalls on conflicts.
module rf_writeback_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall,
    output logic              rf_en,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              ld_pending,
    output logic [REG_AW-1:0] ld_busy_rd,
    output logic              protocol_err
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic              ld_pending_q, ld_pending_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]        ld_funct3_q, ld_funct3_d;
    logic [1:0]        ld_addr_q, ld_addr_d;
    logic              skid_valid_q, skid_valid_d;
    logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]   skid_data_q, skid_data_d;
    logic              rf_en_q, rf_en_d;
    logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              perr_q, perr_d;

    logic            alu_acc, ld_acc, ld_resp, ld_reserved, ld_misaligned;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign stall = (ld_issue && ld_pending_q && !mem_rvalid)
                 || (alu_valid && ld_pending_q && (alu_rd != '0) && (alu_rd == ld_rd_q))
                 || (alu_valid && skid_valid_q);

    assign alu_acc = alu_valid && !stall;
    assign ld_acc  = ld_issue && !stall;
    assign ld_resp = mem_rvalid && ld_pending_q;

    assign ld_reserved   = (ld_funct3 == 3'b011) || (ld_funct3 == 3'b110) || (ld_funct3 == 3'b111);
    assign ld_misaligned = (((ld_funct3 == F3_LH) || (ld_funct3 == F3_LHU)) && ld_addr_lo[0])
                         || ((ld_funct3 == F3_LW) && (ld_addr_lo != 2'b00));

    assign ld_byte = mem_rdata[8*ld_addr_q +: 8];
    assign ld_half = mem_rdata[16*ld_addr_q[1] +: 16];

    always_comb begin
        // NOTE: default first so every path assigns ld_data and no latch is inferred.
        ld_data = mem_rdata;
        case (ld_funct3_q)
            F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        ld_pending_d = ld_pending_q;
        ld_rd_d      = ld_rd_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_d    = ld_addr_q;
        if (ld_acc) begin
            ld_pending_d = 1'b1;
            ld_rd_d      = ld_rd;
            ld_funct3_d  = ld_funct3;
            ld_addr_d    = ld_addr_lo;
        end else if (ld_resp) begin
            ld_pending_d = 1'b0;
        end

        perr_d = perr_q || (mem_rvalid && !ld_pending_q)
                        || (ld_acc && (ld_reserved || ld_misaligned));
    end

    // One write per cycle: load response, then skid entry, then the ALU result.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        rf_en_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wdata_d   = rf_wdata_q;
        if (ld_resp) begin
            rf_en_d    = (ld_rd_q != '0);
            rf_rd_d    = ld_rd_q;
            rf_wdata_d = ld_data;
            if (alu_acc) begin
                skid_valid_d = 1'b1;
                skid_rd_d    = alu_rd;
                skid_data_d  = alu_result;
            end
        end else if (skid_valid_q) begin
            rf_en_d      = (skid_rd_q != '0);
            rf_rd_d      = skid_rd_q;
            rf_wdata_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (alu_acc) begin
            rf_en_d    = (alu_rd != '0);
            rf_rd_d    = alu_rd;
            rf_wdata_d = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pending_q <= 1'b0;
            ld_rd_q      <= '0;
            ld_funct3_q  <= '0;
            ld_addr_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            rf_en_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
            perr_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            ld_pending_q <= ld_pending_d;
            ld_rd_q      <= ld_rd_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_q    <= ld_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            rf_en_q      <= rf_en_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            perr_q       <= perr_d;
        end
    end

    assign rf_en        = rf_en_q;
    assign rf_rd        = rf_rd_q;
    assign rf_wdata     = rf_wdata_q;
    assign ld_pending   = ld_pending_q;
    assign ld_busy_rd   = ld_pending_q ? ld_rd_q : '0;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed self-checking bench for rf_writeback_ctrl with hand-computed expectations.
module tb_rf_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        ld_pending;
    logic [4:0]  ld_busy_rd;
    logic        protocol_err;

    int n_checks = 0;
    int n_pass   = 0;

    rf_writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .ld_pending(ld_pending), .ld_busy_rd(ld_busy_rd), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        ld_issue = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Issue a load, respond one cycle later; result is on the write port on return.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] addr, input logic [31:0] data);
        ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = addr;
        tick();
        ld_issue = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check("reset_rf_en", rf_en, 0);
        check("reset_pending", ld_pending, 0);
        check("reset_perr", protocol_err, 0);
        rst_n = 1'b1;
        tick();

        // ALU-only writes
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234;
        #1 check("alu_stall", stall, 0);
        tick();
        alu_rd = 5'd0; alu_result = 32'hDEAD;
        check("alu_en", rf_en, 1);
        check("alu_rd", rf_rd, 5);
        check("alu_data", rf_wdata, 32'h1234);
        tick();
        idle();
        check("alu_x0_en", rf_en, 0);

        // Load extraction
        ld_issue = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b000; ld_addr_lo = 2'd3;
        tick();
        ld_issue = 1'b0;
        check("lb_pending", ld_pending, 1);
        check("lb_busy_rd", ld_busy_rd, 4);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0011;
        tick();
        idle();
        check("lb_en", rf_en, 1);
        check("lb_rd", rf_rd, 4);
        check("lb_data", rf_wdata, 32'hFFFF_FF80);
        check("lb_cleared", ld_pending, 0);
        check("lb_busy_cleared", ld_busy_rd, 0);
        do_load(5'd4, 3'b101, 2'd2, 32'h80FF_0011);
        check("lhu_data", rf_wdata, 32'h0000_80FF);
        do_load(5'd4, 3'b010, 2'd0, 32'h80FF_0011);
        check("lw_data", rf_wdata, 32'h80FF_0011);
        check("clean_perr", protocol_err, 0);

        // Collision: load response and ALU result in the same cycle
        ld_issue = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
        tick();
        ld_issue = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h99;
        #1 check("coll_stall0", stall, 0);
        tick();
        mem_rvalid = 1'b0;
        alu_rd = 5'd10; alu_result = 32'hAA;
        #1 check("coll_skid_stall", stall, 1);
        check("coll_w1_rd", rf_rd, 7);
        check("coll_w1_data", rf_wdata, 32'h77);
        tick();
        check("coll_w2_en", rf_en, 1);
        check("coll_w2_rd", rf_rd, 9);
        check("coll_w2_data", rf_wdata, 32'h99);
        check("coll_drained_stall", stall, 0);
        tick();
        idle();
        check("coll_w3_rd", rf_rd, 10);
        check("coll_w3_data", rf_wdata, 32'hAA);

        // WAW hazard on a pending load
        ld_issue = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
        tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h33;
        #1 check("waw_stall_a", stall, 1);
        tick();
        check("waw_stall_b", stall, 1);
        check("waw_no_write", rf_en, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h3333;
        tick();
        mem_rvalid = 1'b0;
        #1 check("waw_released", stall, 0);
        check("waw_ld_rd", rf_rd, 3);
        check("waw_ld_data", rf_wdata, 32'h3333);
        tick();
        idle();
        check("waw_alu_data", rf_wdata, 32'h33);

        // Second issue while pending, then issue coinciding with response
        ld_issue = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
        tick();
        ld_rd = 5'd8; ld_funct3 = 3'b100; ld_addr_lo = 2'd1;
        #1 check("ld2_stall", stall, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h66;
        #1 check("ld2_accept", stall, 0);
        tick();
        idle();
        check("ld2_pending", ld_pending, 1);
        check("ld2_busy_rd", ld_busy_rd, 8);
        check("ld2_w_rd", rf_rd, 6);
        check("ld2_w_data", rf_wdata, 32'h66);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_AB00;
        tick();
        idle();
        check("lbu_data", rf_wdata, 32'h0000_00AB);
        check("lbu_cleared", ld_pending, 0);
        check("ld2_perr", protocol_err, 0);

        // Protocol errors
        do_load(5'd11, 3'b011, 2'd0, 32'hCAFE_BABE);
        check("rsv_perr", protocol_err, 1);
        check("rsv_data", rf_wdata, 32'hCAFE_BABE);
        do_reset();
        check("perr_reset", protocol_err, 0);
        do_load(5'd12, 3'b001, 2'd1, 32'h1234_5678);
        check("mis_perr", protocol_err, 1);
        check("mis_data", rf_wdata, 32'h0000_5678);

        // Reset mid-load, then a stale response
        do_reset();
        tick();
        ld_issue = 1'b1; ld_rd = 5'd13; ld_funct3 = 3'b010;
        alu_valid = 1'b1; alu_rd = 5'd14; alu_result = 32'h14;
        tick();
        idle();
        check("mid_pending", ld_pending, 1);
        check("mid_alu_en", rf_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pending", ld_pending, 0);
        check("mid_rst_busy", ld_busy_rd, 0);
        check("mid_rst_en", rf_en, 0);
        check("mid_rst_data", rf_wdata, 0);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555;
        tick();
        idle();
        check("late_perr", protocol_err, 1);
        check("late_no_write", rf_en, 0);
        tick();
        check("late_no_write2", rf_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side controller for the 32x32 register file in the 3-stage pipeline.
- Merges two write sources onto the single register-file write port (rf_en/rd/wdata):
  - single-cycle ALU results;
  - load data returning from data memory.
- Tracks at most one outstanding load, aligns and sign-extends its data, and stalls the pipeline on port conflicts and WAW hazards.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  REG_AW  ALU destination register.
- alu_result  in  XLEN  ALU result.
- ld_issue  in  1  load issued to memory this cycle.
- ld_rd  in  REG_AW  load destination register.
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_addr_lo  in  2  load byte address bits [1:0].
- mem_rvalid  in  1  load response valid (single-cycle pulse).
- mem_rdata  in  XLEN  raw 32-bit memory word.
- stall  out  1  combinational; the offered ALU result or load issue is not accepted this cycle.
- rf_en  out  1  registered register-file write enable.
- rf_rd  out  REG_AW  registered write index.
- rf_wdata  out  XLEN  registered write data.
- ld_pending  out  1  a load is outstanding.
- ld_busy_rd  out  REG_AW  rd of the outstanding load; 0 when none.
- protocol_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): rf_en=0, rf_rd=0, rf_wdata=0, ld_pending=0, ld_busy_rd=0, protocol_err=0, skid buffer empty. Reset mid-load discards the pending load.
- Acceptance: ALU accepted = alu_valid && !stall. Load accepted = ld_issue && !stall. The source holds its inputs while stall=1.
- stall=1 if any of:
  - (a) ld_issue && ld_pending && !mem_rvalid — only one load may be outstanding;
  - (b) alu_valid && ld_pending && alu_rd!=0 && alu_rd==ld_busy_rd — WAW hazard;
  - (c) alu_valid && skid_full.
- Load tracking:
  - An accepted load sets ld_pending and latches rd, funct3 and addr_lo.
  - mem_rvalid while pending clears ld_pending. Issue and response in the same cycle: the latches update to the new load and ld_pending stays 1.
- Write arbitration, one write per cycle, priority load response > skid entry > accepted ALU:
  - An accepted ALU result loses only to a load response in the same cycle. It then enters the 1-entry skid buffer.
  - The skid buffer drains on the first cycle with no load response.
- Write port:
  - The winning write appears on rf_en/rf_rd/rf_wdata one cycle after its source cycle.
  - rf_en=0 when there is no winner or the winner's rd==0. A write to x0 is never emitted but still consumes its slot.
- Load alignment on mem_rdata:
  - byte = mem_rdata[8*addr_lo +: 8].
  - half = mem_rdata[16*addr_lo[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- ld_busy_rd equals the latched rd while pending, else 0. An x0 load is tracked but never causes a WAW stall.
- protocol_err sets (sticky) on any of:
  - mem_rvalid with no load pending, including a late response after reset;
  - accepted load with a reserved funct3 (011, 110, 111) — executed as LW;
  - accepted load that is misaligned: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0 — executed with the lane extraction above.

Test Plan:
- Reset: rst_n=0 mid-load (ld_pending=1) → all outputs 0 immediately. A later mem_rvalid → protocol_err=1, rf_en stays 0.
- ALU-only: alu_valid, rd=5, result=0x1234 → next cycle rf_en=1, rf_rd=5, rf_wdata=0x1234. rd=0 → rf_en=0.
- Load extraction: LB, addr_lo=3, mem_rdata=0x80FF_0011 → rf_wdata=0xFFFF_FF80. LHU, addr_lo=2 → 0x0000_80FF. LW → 0x80FF_0011.
- Collision: mem_rvalid for rd=7 and ALU rd=9 in the same cycle → cycle+1 writes x7, cycle+2 writes x9. An ALU offered on cycle+1 sees stall=1 (skid full).
- Hazards:
  - load to x3 pending, ALU rd=3 → stall=1 until the response cycle;
  - second ld_issue while pending → stall=1;
  - ld_issue coinciding with mem_rvalid → accepted, ld_pending stays 1.
- Errors: ld_funct3=011 → protocol_err=1, data written as full word. LH with addr_lo=1 → protocol_err=1.
